// File: rtl/xor_lfsr_prbs_pkg.sv
// Shared PRBS constants and a reference feedback function for XOR-feedback LFSRs.
// Tap masks use bit i = state[i] in the feedback XOR; the shift direction is toward the MSB.
package prbs_pkg;

  localparam logic [6:0]  TAPS_PRBS7  = 7'h60;
  localparam logic [7:0]  TAPS_PRBS8  = 8'hB8;
  localparam logic [14:0] TAPS_PRBS15 = 15'h6000;

  localparam int MAX_WIDTH = 32;

  // Behavioural feedback, handy for models; the datapath uses xor_reduce_tree.
  function automatic logic xor_fb(input logic [MAX_WIDTH-1:0] state,
                                  input logic [MAX_WIDTH-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/xor_lfsr_prbs_if.sv
// Control/status bundle of the PRBS generator/checker.
// The master side drives the controls; the slave side is the generator.
interface xor_lfsr_prbs_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             chk_valid;
  logic             chk_bit;
  logic [WIDTH-1:0] q;
  logic             bit_out;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic [CNT_W-1:0] err_cnt;
  logic             zero_fix;

  modport master (
    output en, load, seed_in, chk_valid, chk_bit,
    input  q, bit_out, wrap, period, err_cnt, zero_fix
  );

  modport slave (
    input  en, load, seed_in, chk_valid, chk_bit,
    output q, bit_out, wrap, period, err_cnt, zero_fix
  );
endinterface

// File: rtl/xor_lfsr_prbs_xor_reduce_tree.sv
// Balanced XOR reduction: input is zero-padded to a power of two and folded in place
// level by level, so depth is ceil(log2(WIDTH)) two-input XORs.
module xor_reduce_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din_i,
  output logic             dout_o
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int PW     = 1 << LEVELS;

  logic [PW-1:0] acc;

  // Writing acc[k] only clobbers indices below the pair (2k, 2k+1) still to be read.
  always_comb begin
    acc = PW'(din_i);
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < (PW >> (l + 1)); k++) begin
        acc[k] = acc[2*k] ^ acc[2*k+1];
      end
    end
    dout_o = acc[0];
  end
endmodule

// File: rtl/xor_lfsr_prbs.sv
// Fibonacci LFSR PRBS generator with seed load, wrap/period tracking and a
// saturating bit-error checker comparing received bits against the local sequence.
module xor_lfsr_prbs
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_PRBS8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  xor_lfsr_prbs_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             zfix_q, zfix_d;

  logic             fb;
  logic             step;
  logic             seed_zero;
  logic             mismatch;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] seed_eff;

  xor_reduce_tree #(.WIDTH(WIDTH)) u_fb (
    .din_i  (q_q & TAPS),
    .dout_o (fb)
  );

  assign q_nxt     = {q_q[WIDTH-2:0], fb};
  assign step      = (bus.en | bus.chk_valid) & ~bus.load;
  assign seed_zero = (bus.seed_in == '0);
  assign seed_eff  = seed_zero ? SEED : bus.seed_in;
  // Compare against the bit on the wire before this cycle's step.
  assign mismatch  = bus.chk_valid & ~bus.load & (bus.chk_bit != q_q[WIDTH-1]);

  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    steps_d  = steps_q;
    period_d = period_q;
    err_d    = err_q;
    wrap_d   = 1'b0;
    zfix_d   = 1'b0;

    if (bus.load) begin
      q_d     = seed_eff;
      start_d = seed_eff;
      steps_d = '0;
      zfix_d  = seed_zero;
    end else if (step) begin
      q_d = q_nxt;
      if (q_nxt == start_q) begin
        wrap_d   = 1'b1;
        period_d = steps_q + WIDTH'(1);
        steps_d  = '0;
      end else if (steps_q != '1) begin
        steps_d = steps_q + WIDTH'(1);
      end
    end

    if (mismatch && err_q != '1) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= SEED;
      start_q  <= SEED;
      steps_q  <= '0;
      period_q <= '0;
      err_q    <= '0;
      wrap_q   <= 1'b0;
      zfix_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      zfix_q   <= zfix_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.bit_out  = q_q[WIDTH-1];
  assign bus.wrap     = wrap_q;
  assign bus.period   = period_q;
  assign bus.err_cnt  = err_q;
  assign bus.zero_fix = zfix_q;
endmodule

// File: tb/tb_xor_lfsr_prbs.sv
// Bench for xor_lfsr_prbs: vector table, a cycle model feeding a scoreboard queue,
// and hand sequences for wrap, reset and error-counter saturation.
module tb_xor_lfsr_prbs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_lfsr_prbs_if #(.WIDTH(8), .CNT_W(16)) bus ();
  xor_lfsr_prbs_if #(.WIDTH(8), .CNT_W(3))  bus3 ();

  xor_lfsr_prbs #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  xor_lfsr_prbs #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CNT_W(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  q;
    logic        wrap;
    logic [7:0]  period;
    logic [15:0] err;
    logic        zf;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       en, ld;
    logic [7:0] seed;
    logic       cv, inv;
    logic [7:0] exp_q;
    logic       exp_wrap, exp_zf;
    logic [7:0] exp_err;
  } vec_t;
  vec_t tv[10];

  // Behavioural model state
  logic [7:0]  m_q, m_start, m_steps, m_period;
  logic [15:0] m_err;
  logic        m_wrap, m_zf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_apply(input logic r, input logic en, input logic ld,
                         input logic [7:0] sd, input logic cv, input logic cb);
    logic [7:0] nx;
    if (r) begin
      m_q = 8'h01; m_start = 8'h01; m_steps = 0; m_period = 0;
      m_err = 0; m_wrap = 0; m_zf = 0;
      return;
    end
    m_wrap = 0; m_zf = 0;
    if (ld) begin
      m_q     = (sd == 0) ? 8'h01 : sd;
      m_start = m_q;
      m_steps = 0;
      m_zf    = (sd == 0);
    end else if (en || cv) begin
      if (cv && cb != m_q[7] && m_err != 16'hFFFF) m_err++;
      nx = {m_q[6:0], ^(m_q & 8'hB8)};
      if (nx == m_start) begin
        m_wrap = 1; m_period = m_steps + 8'd1; m_steps = 0;
      end else if (m_steps != 8'hFF) begin
        m_steps++;
      end
      m_q = nx;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.q = m_q; e.wrap = m_wrap; e.period = m_period; e.err = m_err; e.zf = m_zf;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_q"},      bus.q,        e.q);
    chk({tag, "_wrap"},   bus.wrap,     e.wrap);
    chk({tag, "_period"}, bus.period,   e.period);
    chk({tag, "_err"},    bus.err_cnt,  e.err);
    chk({tag, "_zf"},     bus.zero_fix, e.zf);
  endtask

  // One clock of stimulus; chk_bit is the model's bit_out, optionally inverted.
  task automatic drive(input logic en, input logic ld, input logic [7:0] sd,
                       input logic cv, input logic inv, input string tag);
    logic cb;
    cb = m_q[7] ^ inv;
    bus.en = en; bus.load = ld; bus.seed_in = sd; bus.chk_valid = cv; bus.chk_bit = cb;
    m_apply(1'b0, en, ld, sd, cv, cb);
    push_exp();
    @(posedge clk); #1;
    pop_cmp(tag);
  endtask

  task automatic do_reset(input logic en, input string tag);
    rst = 1; bus.en = en; bus.load = 0; bus.seed_in = 0; bus.chk_valid = 0; bus.chk_bit = 0;
    m_apply(1'b1, 0, 0, 0, 0, 0);
    push_exp();
    @(posedge clk); #1;
    rst = 0;
    pop_cmp(tag);
  endtask

  initial begin
    int wcnt, wat;
    logic [7:0] l3;
    rst = 1;
    bus.en = 0; bus.load = 0; bus.seed_in = 0; bus.chk_valid = 0; bus.chk_bit = 0;
    bus3.en = 0; bus3.load = 0; bus3.seed_in = 0; bus3.chk_valid = 0; bus3.chk_bit = 0;

    //            en ld seed   cv inv  q      wrap zf err
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'd0};
    tv[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 8'd0};
    tv[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 8'd0};
    tv[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'd0};
    tv[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'd0};
    tv[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0};
    tv[6] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0};
    tv[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h4A, 1'b0, 1'b0, 8'd0};
    tv[8] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'd0};
    tv[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h79, 1'b0, 1'b0, 8'd1};

    // Reset state
    do_reset(1'b0, "reset");
    chk("reset_bit_out", bus.bit_out, 1'b0);

    // Table vectors: steps, zero-seed substitution, load priority, ignored check on load
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].en, tv[i].ld, tv[i].seed, tv[i].cv, tv[i].inv, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tq", i),   bus.q,        tv[i].exp_q);
      chk($sformatf("vec%0d_tbit", i), bus.bit_out,  tv[i].exp_q[7]);
      chk($sformatf("vec%0d_twrap", i), bus.wrap,    tv[i].exp_wrap);
      chk($sformatf("vec%0d_tzf", i),  bus.zero_fix, tv[i].exp_zf);
      chk($sformatf("vec%0d_terr", i), bus.err_cnt,  {8'd0, tv[i].exp_err});
    end

    // Two full maximal-length periods from seed 1
    do_reset(1'b0, "reset2");
    for (int rep = 0; rep < 2; rep++) begin
      wcnt = 0; wat = 0;
      for (int i = 1; i <= 255; i++) begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "period");
        if (bus.wrap) begin wcnt++; wat = i; end
      end
      chk($sformatf("wrap_count%0d", rep), wcnt, 1);
      chk($sformatf("wrap_cycle%0d", rep), wat, 255);
      chk($sformatf("wrap_q%0d", rep), bus.q, 8'h01);
      chk($sformatf("period%0d", rep), bus.period, 8'd255);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "wrap_drop");
    chk("wrap_one_cycle", bus.wrap, 1'b0);

    // Reset mid-sequence discards errors, period and start
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "err_a");
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "err_b");
    drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, "load3c");
    chk("mid_q", bus.q, 8'h3C);
    chk("mid_err", bus.err_cnt, 16'd2);
    do_reset(1'b1, "midrst");
    chk("midrst_q", bus.q, 8'h01);
    chk("midrst_err", bus.err_cnt, 16'd0);
    chk("midrst_period", bus.period, 8'd0);
    chk("midrst_wrap", bus.wrap, 1'b0);

    // Reset on the wrapping step: the pulse must not appear
    for (int i = 0; i < 254; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "prewrap");
    do_reset(1'b1, "wraprst");
    chk("wraprst_wrap", bus.wrap, 1'b0);

    // Loopback then injected errors, en and chk_valid together on some cycles
    for (int i = 0; i < 300; i++) drive(i[0], 1'b0, 8'h00, 1'b1, 1'b0, "loop");
    chk("loop_err0", bus.err_cnt, 16'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "inject");
    chk("inject_err5", bus.err_cnt, 16'd5);

    // Narrow counter saturation on the CNT_W=3 instance
    do_reset(1'b0, "reset3");
    l3 = 8'h01;
    for (int i = 0; i < 12; i++) begin
      bus3.chk_valid = 1; bus3.chk_bit = ~l3[7];
      @(posedge clk); #1;
      l3 = {l3[6:0], ^(l3 & 8'hB8)};
      chk($sformatf("sat_err%0d", i), bus3.err_cnt, (i + 1 > 7) ? 7 : i + 1);
      chk($sformatf("sat_q%0d", i), bus3.q, l3);
    end
    bus3.chk_valid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/xor_lfsr_prbs.md
Name: xor_lfsr_prbs

Overview:
- Parametrised XOR-feedback pseudo-random bit sequence (PRBS) generator with a built-in sequence checker.
- Generalises the single two-input XOR cell into an N-bit Fibonacci LFSR with seed load, wrap detection, period measurement and bit-error counting.
- Used as a stimulus source and link self-test block in benches and datapaths.

Parameters:
WIDTH, 8, LFSR state width (min 3, max 32)
TAPS, 8'hB8, feedback tap mask; bit i set means state[i] enters the feedback XOR
SEED, 1, reset value and substitute for an all-zero load (must be non-zero)
CNT_W, 16, error-counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
en  in  1  advance LFSR one step
load  in  1  load seed_in (priority over en and chk_valid)
seed_in  in  WIDTH  seed value for load
chk_valid  in  1  chk_bit valid this cycle; also advances the LFSR
chk_bit  in  1  received bit to compare against bit_out
q  out  WIDTH  current LFSR state
bit_out  out  1  q[WIDTH-1], current PRBS bit
wrap  out  1  one-cycle pulse: state returned to start value
period  out  WIDTH  step count of last completed cycle
err_cnt  out  CNT_W  saturating mismatch count
zero_fix  out  1  one-cycle pulse: zero seed replaced by SEED

Behaviour:
- Reset (rst=1 at edge): q=SEED, start=SEED, steps=0, period=0, err_cnt=0, wrap=0, zero_fix=0.
- Feedback: fb = XOR-reduce(q & TAPS). Next state = {q[WIDTH-2:0], fb}. bit_out is combinational from q.
- step = (en | chk_valid) & ~load.
- load=1:
  - q=start=seed_in, or SEED if seed_in==0 (zero_fix=1 next cycle).
  - steps=0; wrap not asserted.
  - err_cnt is unchanged.
  - A chk_valid in the same cycle is ignored and not counted.
- step=1:
  - q advances; steps increments.
  - If next state == start: wrap=1 next cycle, period=steps+1, steps=0.
  - Otherwise wrap=0.
- steps saturates at all-ones (non-maximal TAPS that never returns).
- Checker: when chk_valid=1 and load=0, compare chk_bit with bit_out before the step. On mismatch err_cnt+1, saturating at 2^CNT_W-1.
- en and chk_valid both high: single step, single comparison.
- All-zero state is unreachable. No lock-up recovery is needed beyond the load substitution.
- Latency: q, wrap, period, err_cnt and zero_fix are registered, updating at the edge after the cause. wrap and zero_fix are exactly one cycle wide.
- Reset mid-sequence discards start, steps and err_cnt. No pending pulse survives reset.

Decomposition:
- Shared package prbs_pkg: default tap constants (TAPS_PRBS7=7'h60, TAPS_PRBS8=8'hB8, TAPS_PRBS15=15'h6000), feedback function xor_fb(state, taps).
- Sub-module xor_reduce_tree (parametrised WIDTH, combinational XOR reduction) is the natural successor cell. Instantiate it once for feedback.
- Wrap/period tracking and the checker stay in the top module.

Test Plan:
1. Reset, then en=1 for 4 cycles (WIDTH=8, SEED=1) -> q = 0x01, 0x02, 0x04, 0x08, 0x11. bit_out=0 throughout.
2. en held 255 cycles from seed 1 -> wrap pulses exactly once on cycle 255, q=0x01, period=255. Repeat for a second full cycle with identical result.
3. load=1 with seed_in=0x00 -> q=0x01, zero_fix pulses one cycle. load with seed_in=0xA5 plus en=1 same cycle -> q=0xA5, no step.
4. Loopback chk_bit=bit_out with chk_valid=1 for 300 cycles -> err_cnt=0. Then invert chk_bit for 5 cycles -> err_cnt=5.
5. CNT_W=3, continuous mismatches for 12 cycles -> err_cnt saturates at 7.
6. rst asserted mid-sequence (q=0x3C, err_cnt=2) -> next cycle q=0x01, err_cnt=0, period=0, wrap=0.
